// File: rtl/vscale_debug_hart_ctrl.sv
// ---------------------------------------------------------------------------
// vscale_debug_hart_ctrl
//
// Per-hart halt/resume controller sitting between the debug module and one or
// more vscale_pipeline instances. Each hart runs a small 2-bit FSM
// (RUNNING -> HALTING -> HALTED -> RESUMING -> RUNNING). The block also keeps
// the sticky resumeack, havereset and halt-timeout flags, and reports
// any/all summary status over the harts currently selected by the DM.
//
// Handshake: there is no valid/ready pair here. pipe_halt is a level request
// held while a hart is HALTING or HALTED; the pipeline answers with the level
// pipe_halted. pipe_resume is held for the whole RESUMING stay, and the hart
// returns to RUNNING on the first cycle pipe_halted is seen low.
//
// Ports
//   clk, reset_n       clock, asynchronous active-low reset
//   hart_reset         per-hart reset pulse (forces RUNNING, sets havereset)
//   dm_haltreq         level halt request to the selected harts
//   dm_resumereq       resume pulse to the selected harts
//   dm_ackhavereset    pulse, clears havereset on the selected harts
//   dm_hartsel         hart index
//   dm_hasel/hamask    hart array mask, OR-ed into the selection when hasel=1
//   pipe_halted        per-hart "drained and stopped" from the pipeline
//   pipe_halt          per-hart halt/stall level to the pipeline
//   pipe_resume        per-hart, high while the hart is RESUMING
//   any*/all*          summary status over the selected harts
//   anynonexistent     dm_hartsel addresses a hart that does not exist
//   dbg_state          packed per-hart FSM state (hart i at [2i+1:2i])
// ---------------------------------------------------------------------------
module vscale_debug_hart_ctrl #(
    parameter int N_HARTS        = 4,
    parameter int HARTSEL_W      = 5,
    parameter int CNT_W          = 8,
    parameter int TIMEOUT_CYCLES = 200
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [N_HARTS-1:0]     hart_reset,
    input  logic                   dm_haltreq,
    input  logic                   dm_resumereq,
    input  logic                   dm_ackhavereset,
    input  logic [HARTSEL_W-1:0]   dm_hartsel,
    input  logic                   dm_hasel,
    input  logic [N_HARTS-1:0]     dm_hamask,
    input  logic [N_HARTS-1:0]     pipe_halted,
    output logic [N_HARTS-1:0]     pipe_halt,
    output logic [N_HARTS-1:0]     pipe_resume,
    output logic                   anyhalted,
    output logic                   allhalted,
    output logic                   anyrunning,
    output logic                   allrunning,
    output logic                   anyresumeack,
    output logic                   allresumeack,
    output logic                   anyhavereset,
    output logic                   allhavereset,
    output logic                   anytimeout,
    output logic                   anynonexistent,
    output logic [2*N_HARTS-1:0]   dbg_state
);

    typedef enum logic [1:0] {
        ST_RUNNING  = 2'd0,
        ST_HALTING  = 2'd1,
        ST_HALTED   = 2'd2,
        ST_RESUMING = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] TO_CNT = CNT_W'(TIMEOUT_CYCLES);

    state_t             r_state     [N_HARTS];
    logic [CNT_W-1:0]   r_cnt       [N_HARTS];
    logic [N_HARTS-1:0] r_timeout;
    logic [N_HARTS-1:0] r_resumeack;
    logic [N_HARTS-1:0] r_havereset;

    logic [N_HARTS-1:0] w_onehot;
    logic [N_HARTS-1:0] w_sel;
    logic [N_HARTS-1:0] w_halted;
    logic [N_HARTS-1:0] w_running;
    logic               w_sel_any;

    // Out-of-range hartsel decodes to no hart at all.
    always_comb begin
        w_onehot = '0;
        for (int i = 0; i < N_HARTS; i++) begin
            w_onehot[i] = (dm_hartsel == HARTSEL_W'(i));
        end
    end

    assign w_sel     = w_onehot | (dm_hasel ? dm_hamask : '0);
    assign w_sel_any = |w_sel;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < N_HARTS; i++) begin
                r_state[i] <= ST_RUNNING;
                r_cnt[i]   <= '0;
            end
            r_timeout   <= '0;
            r_resumeack <= '0;
            r_havereset <= '1;
        end else begin
            for (int i = 0; i < N_HARTS; i++) begin
                if (hart_reset[i]) begin
                    // Hart reset beats every DM request, including the
                    // havereset acknowledge in the same cycle.
                    r_state[i]     <= ST_RUNNING;
                    r_cnt[i]       <= '0;
                    r_timeout[i]   <= 1'b0;
                    r_resumeack[i] <= 1'b0;
                    r_havereset[i] <= 1'b1;
                end else begin
                    if (dm_ackhavereset && w_sel[i]) begin
                        r_havereset[i] <= 1'b0;
                    end
                    case (r_state[i])
                        ST_RUNNING: begin
                            if (dm_haltreq && w_sel[i]) begin
                                r_state[i] <= ST_HALTING;
                                r_cnt[i]   <= '0;
                            end
                        end
                        ST_HALTING: begin
                            // Once started, a halt runs to completion even if
                            // haltreq drops; a timeout is only a flag.
                            if (pipe_halted[i]) begin
                                r_state[i]   <= ST_HALTED;
                                r_timeout[i] <= 1'b0;
                            end else if (r_cnt[i] != TO_CNT) begin
                                r_cnt[i] <= r_cnt[i] + CNT_W'(1);
                                if (r_cnt[i] + CNT_W'(1) == TO_CNT) begin
                                    r_timeout[i] <= 1'b1;
                                end
                            end
                        end
                        ST_HALTED: begin
                            // haltreq takes priority over a concurrent resume.
                            if (dm_resumereq && w_sel[i] && !dm_haltreq) begin
                                r_state[i]     <= ST_RESUMING;
                                r_resumeack[i] <= 1'b0;
                            end
                        end
                        ST_RESUMING: begin
                            if (!pipe_halted[i]) begin
                                r_state[i]     <= ST_RUNNING;
                                r_resumeack[i] <= 1'b1;
                            end
                        end
                        default: begin
                            r_state[i] <= ST_RUNNING;
                        end
                    endcase
                end
            end
        end
    end

    // Pipeline controls and status are pure decodes of the state registers.
    always_comb begin
        pipe_halt   = '0;
        pipe_resume = '0;
        w_halted    = '0;
        w_running   = '0;
        dbg_state   = '0;
        for (int i = 0; i < N_HARTS; i++) begin
            pipe_halt[i]        = (r_state[i] == ST_HALTING) || (r_state[i] == ST_HALTED);
            pipe_resume[i]      = (r_state[i] == ST_RESUMING);
            w_halted[i]         = (r_state[i] == ST_HALTED);
            w_running[i]        = (r_state[i] == ST_RUNNING);
            dbg_state[2*i +: 2] = r_state[i];
        end
    end

    // all* is forced low for an empty selection; any* is naturally low then.
    assign anyhalted    = |(w_halted & w_sel);
    assign allhalted    = w_sel_any && (&(w_halted | ~w_sel));
    assign anyrunning   = |(w_running & w_sel);
    assign allrunning   = w_sel_any && (&(w_running | ~w_sel));
    assign anyresumeack = |(r_resumeack & w_sel);
    assign allresumeack = w_sel_any && (&(r_resumeack | ~w_sel));
    assign anyhavereset = |(r_havereset & w_sel);
    assign allhavereset = w_sel_any && (&(r_havereset | ~w_sel));
    assign anytimeout   = |(r_timeout & w_sel);

    assign anynonexistent = ({1'b0, dm_hartsel} >= (HARTSEL_W + 1)'(N_HARTS));

endmodule

// File: tb/tb_vscale_debug_hart_ctrl.sv
module tb_vscale_debug_hart_ctrl;

    localparam int N = 4;

    logic          clk;
    logic          reset_n;
    logic [N-1:0]  hart_reset;
    logic          dm_haltreq;
    logic          dm_resumereq;
    logic          dm_ackhavereset;
    logic [4:0]    dm_hartsel;
    logic          dm_hasel;
    logic [N-1:0]  dm_hamask;
    logic [N-1:0]  pipe_halted;
    logic [N-1:0]  pipe_halt;
    logic [N-1:0]  pipe_resume;
    logic          anyhalted, allhalted, anyrunning, allrunning;
    logic          anyresumeack, allresumeack, anyhavereset, allhavereset;
    logic          anytimeout, anynonexistent;
    logic [2*N-1:0] dbg_state;

    int n_cmp = 0;
    int n_err = 0;

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    vscale_debug_hart_ctrl #(
        .N_HARTS(4), .HARTSEL_W(5), .CNT_W(8), .TIMEOUT_CYCLES(200)
    ) dut (
        .clk(clk), .reset_n(reset_n), .hart_reset(hart_reset),
        .dm_haltreq(dm_haltreq), .dm_resumereq(dm_resumereq),
        .dm_ackhavereset(dm_ackhavereset), .dm_hartsel(dm_hartsel),
        .dm_hasel(dm_hasel), .dm_hamask(dm_hamask), .pipe_halted(pipe_halted),
        .pipe_halt(pipe_halt), .pipe_resume(pipe_resume),
        .anyhalted(anyhalted), .allhalted(allhalted),
        .anyrunning(anyrunning), .allrunning(allrunning),
        .anyresumeack(anyresumeack), .allresumeack(allresumeack),
        .anyhavereset(anyhavereset), .allhavereset(allhavereset),
        .anytimeout(anytimeout), .anynonexistent(anynonexistent),
        .dbg_state(dbg_state)
    );

    // ---------------- driver / checker tasks ----------------
    // Advance one rising edge; inputs change and outputs are sampled 1ns later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Status vector: {anyhalted, allhalted, anyrunning, allrunning,
    //                 anyresumeack, allresumeack, anyhavereset, allhavereset, anytimeout}
    function automatic logic [31:0] status();
        return {23'd0, anyhalted, allhalted, anyrunning, allrunning,
                anyresumeack, allresumeack, anyhavereset, allhavereset, anytimeout};
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        reset_n         = 1'b0;
        hart_reset      = '0;
        dm_haltreq      = 1'b0;
        dm_resumereq    = 1'b0;
        dm_ackhavereset = 1'b0;
        dm_hartsel      = 5'd0;
        dm_hasel        = 1'b0;
        dm_hamask       = '0;
        pipe_halted     = '0;

        repeat (2) step();
        check("rst_pipe_halt", 32'(pipe_halt), 32'h0);
        check("rst_pipe_resume", 32'(pipe_resume), 32'h0);
        check("rst_dbg_state", 32'(dbg_state), 32'h0);
        reset_n = 1'b1;
        step();

        // Reset state of hart 0: running, havereset, no resumeack.
        check("rst_status_h0", status(), 32'b0_0_1_1_0_0_1_1_0);
        check("exists_h0", 32'(anynonexistent), 32'h0);

        dm_ackhavereset = 1'b1;
        step();
        dm_ackhavereset = 1'b0;
        check("ackhr_h0", 32'(anyhavereset), 32'h0);
        dm_hartsel = 5'd1;
        #1;
        check("ackhr_h1_untouched", 32'(anyhavereset), 32'h1);

        // Halt hart 2.
        dm_hartsel = 5'd2;
        dm_haltreq = 1'b1;
        step();
        check("halting_pipe_halt", 32'(pipe_halt), 32'h4);
        check("halting_status", status(), 32'b0_0_0_0_0_0_1_1_0);
        repeat (4) step();
        check("halting_still", 32'(dbg_state[5:4]), 32'h1);
        pipe_halted[2] = 1'b1;
        step();
        check("halted_all", 32'(allhalted), 32'h1);
        check("halted_pipe_halt", 32'(pipe_halt), 32'h4);

        // Resume is ignored while haltreq is still high.
        dm_resumereq = 1'b1;
        step();
        dm_resumereq = 1'b0;
        check("resume_blocked", 32'(pipe_resume), 32'h0);

        // Resume hart 2.
        dm_haltreq   = 1'b0;
        dm_resumereq = 1'b1;
        step();
        dm_resumereq = 1'b0;
        check("resuming_pipe_resume", 32'(pipe_resume), 32'h4);
        check("resuming_pipe_halt", 32'(pipe_halt), 32'h0);
        check("resuming_status", status(), 32'b0_0_0_0_0_0_1_1_0);
        step();
        check("resuming_hold", 32'(pipe_resume), 32'h4);
        pipe_halted[2] = 1'b0;
        step();
        check("resumed_status", status(), 32'b0_0_1_1_1_1_1_1_0);
        check("resumed_pipe_resume", 32'(pipe_resume), 32'h0);

        // Hart array halt on harts 0,1,3; hart 3 never halts.
        dm_hartsel = 5'd0;
        dm_hasel   = 1'b1;
        dm_hamask  = 4'b1011;
        dm_haltreq = 1'b1;
        step();                              // edge index 0: HALTING entered
        check("array_pipe_halt", 32'(pipe_halt), 32'hb);
        dm_haltreq  = 1'b0;                  // must not abort the halt
        pipe_halted = 4'b0011;
        step();                              // edge index 1
        check("array_status", status(), 32'b1_0_0_0_0_0_1_0_0);
        repeat (198) step();                 // edge index 199
        check("timeout_not_yet", 32'(anytimeout), 32'h0);
        check("timeout_h3_halting", 32'(dbg_state[7:6]), 32'h1);
        step();                              // edge index 200
        check("timeout_set", 32'(anytimeout), 32'h1);
        check("timeout_pipe_halt", 32'(pipe_halt), 32'hb);

        // Nonexistent hart, empty selection.
        dm_hasel   = 1'b0;
        dm_hartsel = 5'd7;
        #1;
        check("nonexist_flag", 32'(anynonexistent), 32'h1);
        check("nonexist_status", status(), 32'h0);

        // Hart 1: ack its havereset, then hart_reset racing an ack.
        dm_hartsel      = 5'd1;
        dm_ackhavereset = 1'b1;
        step();
        dm_ackhavereset = 1'b0;
        check("h1_ack", 32'(anyhavereset), 32'h0);
        check("h1_halted", 32'(allhalted), 32'h1);
        hart_reset[1]   = 1'b1;
        dm_ackhavereset = 1'b1;
        step();
        hart_reset[1]   = 1'b0;
        dm_ackhavereset = 1'b0;
        check("h1_reset_wins", status(), 32'b0_0_1_1_0_0_1_1_0);
        check("h1_reset_pipe_halt", 32'(pipe_halt), 32'h9);

        // Asynchronous reset while hart 3 is HALTING.
        dm_hartsel = 5'd3;
        #2;
        reset_n = 1'b0;
        #1;
        check("async_rst_pipe_halt", 32'(pipe_halt), 32'h0);
        check("async_rst_status_h3", status(), 32'b0_0_1_1_0_0_1_1_0);
        step();
        reset_n = 1'b1;
        step();
        check("post_rst_state", 32'(dbg_state), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Bound the run in case the stimulus ever stalls.
    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1);
    end

endmodule
